// File: rtl/spi_flash_reader.sv
// Fetches one 32-bit little-endian word from a SPI NOR flash (mode 0, clk/2) per rstrb.
// Optional macro SPI_FLASH_FASTREAD_EN selects command 0x0B with 8 dummy SPI clocks.
module spi_flash_reader #(
  parameter int ADDR_WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  rstrb,
  input  logic [ADDR_WIDTH-1:0] word_address,
  output logic [31:0]           rdata,
  output logic                  rbusy,
  output logic                  spi_cs_n,
  output logic                  spi_clk,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

`ifdef SPI_FLASH_FASTREAD_EN
  localparam logic [7:0] CMD = 8'h0B;
  typedef enum logic [2:0] {IDLE, SEND, DUMMY, RECV, DONE} state_t;
`else
  localparam logic [7:0] CMD = 8'h03;
  typedef enum logic [2:0] {IDLE, SEND, RECV, DONE} state_t;
`endif

  state_t      state_reg, state_next;
  logic [31:0] shift_reg, shift_next;
  logic [31:0] rx_reg, rx_next;
  logic [5:0]  bit_cnt_reg, bit_cnt_next;
  logic        phase_reg, phase_next;
  logic        cs_n_reg, cs_n_next;
  logic        sclk_reg, sclk_next;
  logic        mosi_reg, mosi_next;
  logic        busy_reg, busy_next;
  logic [31:0] rdata_reg, rdata_next;

  logic [23:0] byte_addr;
  logic [31:0] frame;
  logic        bit_last;

  // Byte address is the word address times four, zero-padded or truncated to 24 bits.
  generate
    if (ADDR_WIDTH >= 22) begin : g_addr_trunc
      assign byte_addr = {word_address[21:0], 2'b00};
    end else begin : g_addr_pad
      assign byte_addr = {{(22 - ADDR_WIDTH){1'b0}}, word_address, 2'b00};
    end
  endgenerate

  assign frame    = {CMD, byte_addr};
  assign bit_last = (bit_cnt_reg == 6'd1);

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      rx_reg      <= '0;
      bit_cnt_reg <= '0;
      phase_reg   <= 1'b0;
      cs_n_reg    <= 1'b1;
      sclk_reg    <= 1'b0;
      mosi_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      rdata_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      rx_reg      <= rx_next;
      bit_cnt_reg <= bit_cnt_next;
      phase_reg   <= phase_next;
      cs_n_reg    <= cs_n_next;
      sclk_reg    <= sclk_next;
      mosi_reg    <= mosi_next;
      busy_reg    <= busy_next;
      rdata_reg   <= rdata_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    rx_next      = rx_reg;
    bit_cnt_next = bit_cnt_reg;
    phase_next   = phase_reg;
    cs_n_next    = cs_n_reg;
    sclk_next    = sclk_reg;
    mosi_next    = mosi_reg;
    busy_next    = busy_reg;
    rdata_next   = rdata_reg;

    case (state_reg)
      IDLE: begin
        if (rstrb) begin
          state_next   = SEND;
          cs_n_next    = 1'b0;
          busy_next    = 1'b1;
          sclk_next    = 1'b0;
          phase_next   = 1'b0;
          mosi_next    = frame[31];
          shift_next   = {frame[30:0], 1'b0};
          bit_cnt_next = 6'd32;
        end
      end

      SEND: begin
        if (!phase_reg) begin
          sclk_next  = 1'b1;
          phase_next = 1'b1;
        end else begin
          // End of a high phase: the next bit goes out as spi_clk drops.
          sclk_next  = 1'b0;
          phase_next = 1'b0;
          if (bit_last) begin
            mosi_next = 1'b0;
`ifdef SPI_FLASH_FASTREAD_EN
            state_next   = DUMMY;
            bit_cnt_next = 6'd8;
`else
            state_next   = RECV;
            bit_cnt_next = 6'd32;
`endif
          end else begin
            mosi_next    = shift_reg[31];
            shift_next   = {shift_reg[30:0], 1'b0};
            bit_cnt_next = bit_cnt_reg - 6'd1;
          end
        end
      end

`ifdef SPI_FLASH_FASTREAD_EN
      DUMMY: begin
        mosi_next = 1'b0;
        if (!phase_reg) begin
          sclk_next  = 1'b1;
          phase_next = 1'b1;
        end else begin
          sclk_next  = 1'b0;
          phase_next = 1'b0;
          if (bit_last) begin
            state_next   = RECV;
            bit_cnt_next = 6'd32;
          end else begin
            bit_cnt_next = bit_cnt_reg - 6'd1;
          end
        end
      end
`endif

      RECV: begin
        mosi_next = 1'b0;
        if (!phase_reg) begin
          sclk_next  = 1'b1;
          phase_next = 1'b1;
        end else begin
          sclk_next  = 1'b0;
          phase_next = 1'b0;
          rx_next    = {rx_reg[30:0], spi_miso};
          if (bit_last) begin
            state_next   = DONE;
            bit_cnt_next = 6'd0;
          end else begin
            bit_cnt_next = bit_cnt_reg - 6'd1;
          end
        end
      end

      DONE: begin
        // First received byte sits in rx_reg[31:24]; it belongs in rdata[7:0].
        state_next = IDLE;
        cs_n_next  = 1'b1;
        sclk_next  = 1'b0;
        mosi_next  = 1'b0;
        busy_next  = 1'b0;
        rdata_next = {rx_reg[7:0], rx_reg[15:8], rx_reg[23:16], rx_reg[31:24]};
      end

      default: state_next = IDLE;
    endcase
  end

  assign rdata    = rdata_reg;
  assign rbusy    = busy_reg;
  assign spi_cs_n = cs_n_reg;
  assign spi_clk  = sclk_reg;
  assign spi_mosi = mosi_reg;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: flash model on the SPI pins, transaction-level model of
// the expected pin and bus behaviour, checked every clk on the falling edge.
module tb_spi_flash_reader;
  localparam int AW = 20;
`ifdef SPI_FLASH_FASTREAD_EN
  localparam int         LAT = 145;
  localparam int         DUM = 8;
  localparam logic [7:0] CMD = 8'h0B;
`else
  localparam int         LAT = 129;
  localparam int         DUM = 0;
  localparam logic [7:0] CMD = 8'h03;
`endif

  logic          clk = 1'b0;
  logic          RESET = 1'b0;
  logic          rstrb = 1'b0;
  logic [AW-1:0] word_address = '0;
  logic [31:0]   rdata;
  logic          rbusy;
  logic          spi_cs_n;
  logic          spi_clk;
  logic          spi_mosi;
  logic          spi_miso = 1'b0;

  always #5 clk = ~clk;

  spi_flash_reader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .RESET(RESET), .rstrb(rstrb), .word_address(word_address),
    .rdata(rdata), .rbusy(rbusy), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Flash contents: a few fixed bytes at 0x80, a simple arithmetic pattern elsewhere.
  function automatic logic [7:0] fb(input logic [23:0] a);
    if (a == 24'h80) return 8'h13;
    if (a >= 24'h81 && a <= 24'h83) return 8'h00;
    return 8'(a * 7 + 3);
  endfunction

  function automatic logic [23:0] byte_addr_of(input logic [AW-1:0] w);
    return 24'({w, 2'b00});
  endfunction

  // Transaction model: counts down the fixed fetch latency after an accepted strobe.
  int          m_cnt = 0;
  logic [31:0] m_frame = '0;
  logic [31:0] m_pend = '0;
  logic [31:0] exp_rdata = '0;

  always @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      m_cnt     <= 0;
      exp_rdata <= '0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) exp_rdata <= m_pend;
    end else if (rstrb) begin
      m_cnt   <= LAT;
      m_frame <= {CMD, byte_addr_of(word_address)};
      m_pend  <= {fb(byte_addr_of(word_address) + 24'd3), fb(byte_addr_of(word_address) + 24'd2),
                  fb(byte_addr_of(word_address) + 24'd1), fb(byte_addr_of(word_address))};
    end
  end

  // Per-cycle comparison: cycle c of a fetch has spi_clk high on odd c, frame bit c/2 on mosi.
  always @(negedge clk) begin : cmp
    int   c;
    logic e_clk;
    logic e_mosi;
    if (chk_en) begin
      c      = LAT - m_cnt;
      e_clk  = (m_cnt != 0) && (c < LAT - 1) && (c % 2 == 1);
      e_mosi = 1'b0;
      if (m_cnt != 0 && c < 64) e_mosi = m_frame[31 - c / 2];
      check("rbusy", 32'(rbusy), 32'(m_cnt != 0));
      check("spi_cs_n", 32'(spi_cs_n), 32'(m_cnt == 0));
      check("spi_clk", 32'(spi_clk), 32'(e_clk));
      check("spi_mosi", 32'(spi_mosi), 32'(e_mosi));
      check("rdata", rdata, exp_rdata);
    end
  end

  // Flash model: captures command/address on rising spi_clk, presents data bits after them.
  int          fl_n = 0;
  logic [31:0] fl_frame = '0;
  int          frames = 0;
  int          sclk_edges = 0;

  always @(posedge spi_clk or posedge spi_cs_n) begin : flash
    int         j;
    logic [7:0] b;
    if (spi_cs_n) begin
      fl_n = 0;
    end else begin
      fl_n = fl_n + 1;
      if (fl_n <= 32) begin
        fl_frame = {fl_frame[30:0], spi_mosi};
      end else if (fl_n > 32 + DUM) begin
        j = fl_n - 33 - DUM;
        b = fb(fl_frame[23:0] + 24'(j / 8));
        spi_miso <= b[7 - j % 8];
      end
    end
  end

  always @(negedge spi_cs_n) frames <= frames + 1;
  always @(posedge spi_clk) sclk_edges <= sclk_edges + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input logic [AW-1:0] a, output int t0);
    word_address = a;
    rstrb = 1'b1;
    @(negedge clk);
    rstrb = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_idle(input int t0, output int lat);
    bit done;
    done = 1'b0;
    lat = -1;
    for (int k = 0; k < 400 && !done; k++) begin
      if (!rbusy) begin
        lat  = cyc - t0;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: rbusy still 1 after 400 cycles, expected 0");
    end
  endtask

  int t0, lat, f0, e0;

  initial begin
    // Reset state
    tick(3);
    check("rst_cs_n", 32'(spi_cs_n), 32'd1);
    check("rst_sclk", 32'(spi_clk), 32'd0);
    check("rst_rbusy", 32'(rbusy), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    RESET  = 1'b1;
    chk_en = 1'b1;
    tick(2);

    // Basic fetch at word 0x20 (byte 0x80)
    start(20'h00020, t0);
    wait_idle(t0, lat);
    $display("fetch word 0x00020: rdata=%h latency=%0d frame=%h", rdata, lat, fl_frame);
    check("lat1", 32'(lat), 32'(LAT));
    check("rdata1", rdata, 32'h00000013);
    check("model_rdata1", exp_rdata, 32'h00000013);
    check("frame1", fl_frame, {CMD, 24'h000080});
    tick(3);

    // Strobes during a fetch are ignored
    f0 = frames;
    start(20'h00100, t0);
    tick(9);
    word_address = 20'h00003;
    rstrb = 1'b1;
    @(negedge clk);
    rstrb = 1'b0;
    tick(39);
    rstrb = 1'b1;
    @(negedge clk);
    rstrb = 1'b0;
    word_address = 20'h00055;
    wait_idle(t0, lat);
    tick(5);
    $display("fetch word 0x00100 with extra strobes: rdata=%h latency=%0d frames=%0d", rdata, lat, frames - f0);
    check("lat2", 32'(lat), 32'(LAT));
    check("rdata2", rdata, 32'h18110A03);
    check("frames2", 32'(frames - f0), 32'd1);

    // Back-to-back fetches
    f0 = frames;
    start(20'h00001, t0);
    wait_idle(t0, lat);
    $display("fetch word 0x00001: rdata=%h latency=%0d", rdata, lat);
    check("rdata3a", rdata, 32'h342D261F);
    check("gap_cs_high", 32'(spi_cs_n), 32'd1);
    start(20'h00002, t0);
    check("gap_cs_low", 32'(spi_cs_n), 32'd0);
    check("gap_rbusy", 32'(rbusy), 32'd1);
    wait_idle(t0, lat);
    $display("fetch word 0x00002: rdata=%h latency=%0d", rdata, lat);
    check("lat3b", 32'(lat), 32'(LAT));
    check("rdata3b", rdata, 32'h5049423B);
    check("frames3", 32'(frames - f0), 32'd2);

    // Reset mid-frame
    #2 RESET = 1'b0;
    tick(2);
    RESET = 1'b1;
    tick(2);
    start(20'h00007, t0);
    tick(40);
    #2 RESET = 1'b0;
    #1;
    e0 = sclk_edges;
    f0 = frames;
    $display("reset at fetch cycle 40: cs_n=%b rbusy=%b rdata=%h", spi_cs_n, rbusy, rdata);
    check("abort_cs_n", 32'(spi_cs_n), 32'd1);
    check("abort_rbusy", 32'(rbusy), 32'd0);
    check("abort_rdata", rdata, 32'd0);
    check("abort_sclk", 32'(spi_clk), 32'd0);
    tick(3);
    RESET = 1'b1;
    tick(20);
    check("abort_edges", 32'(sclk_edges - e0), 32'd0);
    check("abort_frames", 32'(frames - f0), 32'd0);
    check("abort_idle", 32'(rbusy), 32'd0);

    // Highest word address
    start(20'hFFFFF, t0);
    wait_idle(t0, lat);
    $display("fetch word 0xFFFFF: rdata=%h latency=%0d frame=%h", rdata, lat, fl_frame);
    check("lat5", 32'(lat), 32'(LAT));
    check("frame5", fl_frame, {CMD, 24'h3FFFFC});
    check("rdata5", rdata, 32'hFCF5EEE7);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
